// File: rtl/peb_fifo.sv
// DEPTH-entry valid/ready elastic FIFO. o_vld/o_rdy and the status flags are all flops.
// Entries are counted and a synchronous flush is provided.
module peb_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_vld,
    output logic                       o_rdy,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_vld,
    input  logic                       i_rdy,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_afull,
    output logic                       o_aempty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          vld_q, vld_d;
    logic          rdy_q, rdy_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          push, pop;

    // Handshakes use the registered flags, so neither side sees a combinational loop.
    assign push = i_vld && rdy_q;
    assign pop  = vld_q && i_rdy;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (i_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
        vld_d    = (count_d != '0);
        rdy_d    = (count_d != DEPTH_C);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b1;
            afull_q  <= (AF_LEVEL == 0);
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push && !i_flush && !rst) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data   = mem_q[rd_ptr_q];
    assign o_vld    = vld_q;
    assign o_rdy    = rdy_q;
    assign o_count  = count_q;
    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;

endmodule
